// File: rtl/counter_pkg.sv
// Shared constants for the counter scheduler: FSM state encoding and default width.
package counter_pkg;

    localparam int COUNTER_WIDTH = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/counter_sched_if.sv
// Client/counter-side bundle for counter_sched; the slave modport is the scheduler.
interface counter_sched_if #(
    parameter int WIDTH = counter_pkg::COUNTER_WIDTH
);
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic [WIDTH-1:0] cnt_q;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             cnt_clr;
    logic             cnt_en;
    logic             busy;

    modport master (
        output req, len0, len1, cnt_q,
        input  gnt, done, cnt_clr, cnt_en, busy
    );

    modport slave (
        input  req, len0, len1, cnt_q,
        output gnt, done, cnt_clr, cnt_en, busy
    );
endinterface

// File: rtl/counter_4bit.sv
// Up-counter datapath shared by the scheduler's clients: sync clear wins over enable.
module counter_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr)     q_d = '0;
        else if (en) q_d = q_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; last=1 means client 1 was served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end
endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler that clears and runs a shared counter for one of two clients.
module counter_sched
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    counter_sched_if.slave  bus
);
    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] len_r_q, len_r_d;
    logic [1:0]       win;
    logic [WIDTH-1:0] win_len;
    logic [1:0]       owner_oh;
    logic             owner_req;

    rr_arb2 u_arb (
        .req  (bus.req),
        .last (last_q),
        .win  (win)
    );

    assign win_len   = win[1] ? bus.len1 : bus.len0;
    assign owner_oh  = owner_q ? 2'b10 : 2'b01;
    assign owner_req = bus.req[owner_q];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        len_r_d = len_r_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    owner_d = win[1];
                    len_r_d = win_len;
                    state_d = (win_len == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!owner_req) begin
                    state_d = S_IDLE;
                    last_d  = owner_q;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Abort takes priority over reaching the target length.
                if (!owner_req) begin
                    state_d = S_IDLE;
                    last_d  = owner_q;
                end else if (bus.cnt_q == len_r_q) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                last_d  = owner_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            len_r_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            len_r_q <= len_r_d;
        end
    end

    assign bus.gnt     = (state_q != S_IDLE) ? owner_oh : 2'b00;
    assign bus.done    = (state_q == S_DONE) ? owner_oh : 2'b00;
    assign bus.cnt_clr = (state_q == S_CLEAR);
    assign bus.busy    = (state_q != S_IDLE);
    // Only output with a combinational input path: stops the instant the target is seen.
    assign bus.cnt_en  = (state_q == S_RUN) && owner_req && (bus.cnt_q != len_r_q);
endmodule

// File: doc/counter_sched.md
# counter_sched

Two-requester scheduler that shares one 4-bit up-counter (the `counter_4bit` datapath) between two clients. It arbitrates round-robin, clears the counter, and enables counting for the granted client's requested length. It signals completion with a one-cycle `done` pulse. It sits between the client logic and the counter; the counter's own enable/clear are driven only by this block.

## Interface
- `WIDTH`, default 4: counter width; `len*` and `cnt_q` width.
- `clk`  in  1  rising-edge clock; the single clock of the block.
- `reset`  in  1  asynchronous, active-low reset. Asserting it (0) forces reset state immediately.
- `req`  in  2  per-client level request; held high until `done` for that client.
- `len0`  in  WIDTH  count length for client 0, sampled at grant.
- `len1`  in  WIDTH  count length for client 1, sampled at grant.
- `cnt_q`  in  WIDTH  current counter value, registered in the counter.
- `gnt`  out  2  one-hot grant; 00 when idle.
- `done`  out  2  one-cycle completion pulse for the granted client.
- `cnt_clr`  out  1  synchronous clear to the counter.
- `cnt_en`  out  1  increment enable to the counter.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Reset values: state IDLE, `gnt`=00, `done`=00, `cnt_clr`=0, `cnt_en`=0, `busy`=0.
- Reset sets the round-robin pointer to "last granted = client 1", so client 0 wins the first contention.
- States: IDLE, CLEAR, RUN, DONE.
- **IDLE**
  - If `req` is non-zero, pick the winner. Only one requesting client wins outright; if both request, the client not last granted wins.
  - Latch the winner's `len` into `len_r` and record the winner in `owner`.
  - If `len`=0, go to DONE. Otherwise go to CLEAR.
- **CLEAR:** `cnt_clr`=1 and `gnt[owner]`=1 for exactly one cycle, then go to RUN.
- **RUN:** `gnt[owner]`=1.
  - `cnt_en` = (`cnt_q` != `len_r`), combinational on `cnt_q`.
  - When `cnt_q` == `len_r`, go to DONE.
  - The counter is enabled for exactly `len_r` cycles.
- **DONE:** `done[owner]`=1 and `gnt[owner]`=1 for one cycle. Update the pointer to `owner`, then go to IDLE.
- **Abort:** if `req[owner]` falls in CLEAR or RUN:
  - `cnt_en`=0 in that cycle;
  - next state is IDLE;
  - no `done` pulse;
  - the pointer is still updated to `owner`.
- `req[owner]` in the DONE cycle is ignored.
- A `req` still high in IDLE after DONE is treated as a new request.
- Length compare is equality only; `len`=2^WIDTH−1 is legal, and no wrap of `cnt_q` occurs.
- Changes on `len0`/`len1` after grant have no effect.

## Timing
- Request in cycle 0 (IDLE) → `gnt` and `cnt_clr` in cycle 1 → RUN in cycles 2..2+L → `done` in cycle L+3 → `gnt`=00 in cycle L+4.
- `len`=0: `gnt` and `done` in cycle 1, IDLE in cycle 2. `cnt_clr` and `cnt_en` are never asserted.
- Back-to-back service: the next grant can occur the cycle after `gnt` drops, which gives a minimum 1 idle cycle between jobs.
- `gnt`, `done`, `cnt_clr` and `busy` are registered-state decodes (Moore). `cnt_en` is the only output with a combinational path from an input (`cnt_q`).
- Reset mid-operation (any state): all outputs go to 0 asynchronously. The counter value is left as is; the next job clears it.

## Structure
- Shared package `counter_pkg`:
  - state encoding constants `S_IDLE`=2'd0, `S_CLEAR`=2'd1, `S_RUN`=2'd2, `S_DONE`=2'd3;
  - default `WIDTH`.
- Sub-module `rr_arb2`: combinational 2-way round-robin pick from `req` and the last-grant bit, producing the one-hot winner.
- The FSM, `len_r`, `owner` and the pointer register live in `counter_sched`.
- The bench instantiates `counter_sched` together with `counter_4bit` for end-to-end checks.

## Test plan
- Reset: hold `reset`=0 with `req`=11. Required: all outputs 0. Release reset. Required: client 0 is granted first (`gnt`=01).
- Single job: `req`=01, `len0`=5. Required:
  - `cnt_clr` in cycle 1;
  - exactly 5 `cnt_en` cycles;
  - `cnt_q` ends at 5;
  - `done`=01 in cycle 8;
  - `gnt`=00 in cycle 9.
- Contention: `req`=11 held, `len0`=3, `len1`=2. Required: grants alternate 01, 10, 01. Each job produces a `done` pulse only for its owner.
- Zero length: `req`=10, `len1`=0. Required: `gnt`=10 and `done`=10 in cycle 1; no `cnt_clr` and no `cnt_en`.
- Abort: `req`=01, `len0`=10, drop `req[0]` at the 4th RUN cycle. Required: `cnt_en`=0 in that cycle, return to IDLE, no `done`. A following `req`=11 grants client 1.
- Mid-run reset: assert `reset`=0 during RUN with `cnt_q`=7. Required: outputs go to 0 immediately. After release, a new job starts with `cnt_clr`.
